// File: rtl/regfile_dumper.sv
// Streams an inclusive, wrapping address range of a register file out over a
// valid/ready handshake, one (address, data) pair per word, then pulses done.
module regfile_dumper #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cur_q, cur_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         last_q      <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // The word is held after acceptance; only the next FETCH overwrites it.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               cur_d   = first_addr;
               last_d  = last_addr;
               state_d = FETCH;
            end
         end
         FETCH: begin
            out_data_d  = rd_data;
            out_addr_d  = cur_q;
            out_valid_d = 1'b1;
            state_d     = SEND;
         end
         SEND: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (cur_q == last_q) begin
                  state_d = DONE;
               end else begin
                  cur_d   = cur_q + ADDR_W'(1);
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy      = (state_q == FETCH) || (state_q == SEND);
      done      = (state_q == DONE);
      rd_addr   = cur_q;
      out_addr  = out_addr_q;
      out_data  = out_data_q;
      out_valid = out_valid_q;
   end

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: a register-file model feeds rd_data and a
// scoreboard queue holds the words each run must deliver, in order.
module tb_regfile_dumper;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } word_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [4:0]  firstAddr;
   logic [4:0]  lastAddr;
   logic [4:0]  rdAddr;
   logic [31:0] rdData;
   logic [4:0]  outAddr;
   logic [31:0] outData;
   logic        outValid;
   logic        outReady;
   logic        busy;
   logic        done;

   logic [31:0] regs [32];
   word_t       sb [$];
   int          checks;
   int          errors;

   regfile_dumper #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .first_addr (firstAddr),
      .last_addr  (lastAddr),
      .rd_addr    (rdAddr),
      .rd_data    (rdData),
      .out_addr   (outAddr),
      .out_data   (outData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .busy       (busy),
      .done       (done)
   );

   assign rdData = regs[rdAddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One complete run: the first word is offered in cycle 2 and each word
   // occupies one FETCH cycle plus (1 + stall) SEND cycles.
   task automatic applyStimulus(input logic [4:0] first, input logic [4:0] last,
                                input int stall, input bit interfere);
      logic [4:0] diff;
      logic [4:0] a;
      int         n;
      int         period;
      int         o;
      logic       expValid;
      word_t      lastWord;
      diff   = last - first;
      n      = int'(diff) + 1;
      period = 2 + stall;
      for (int i = 0; i < n; i++) begin
         a = first + 5'(i);
         sb.push_back('{a, regs[a]});
      end
      lastWord  = sb[sb.size()-1];
      firstAddr = first;
      lastAddr  = last;
      start     = 1'b1;
      outReady  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= n * period + 1; c++) begin
         if (c <= n * period) begin
            o        = (c - 1) % period;
            expValid = (o != 0);
            checkOutput("busy", 64'(busy), 64'(1));
            checkOutput("done_low", 64'(done), 64'(0));
            checkOutput("valid", 64'(outValid), 64'(expValid));
            if (o == 0) begin
               checkOutput("rd_addr", 64'(rdAddr), 64'(sb[0].addr));
            end else begin
               checkOutput("out_addr", 64'(outAddr), 64'(sb[0].addr));
               checkOutput("out_data", 64'(outData), 64'(sb[0].data));
               if (o == period - 1) sb.delete(0);
            end
            outReady = !(o >= 1 && o < period - 1);
            if (interfere && (c == 3 || c == 4)) begin
               start     = 1'b1;
               firstAddr = first + 5'd9;
               lastAddr  = last + 5'd17;
            end else begin
               start = 1'b0;
            end
         end else begin
            checkOutput("done_pulse", 64'(done), 64'(1));
            checkOutput("busy_done", 64'(busy), 64'(0));
            checkOutput("valid_done", 64'(outValid), 64'(0));
            checkOutput("hold_addr", 64'(outAddr), 64'(lastWord.addr));
            checkOutput("hold_data", 64'(outData), 64'(lastWord.data));
         end
         @(posedge clk); #1;
      end
      checkOutput("done_once", 64'(done), 64'(0));
      checkOutput("idle_busy", 64'(busy), 64'(0));
      checkOutput("idle_valid", 64'(outValid), 64'(0));
      if (interfere) begin
         @(posedge clk); #1;
         checkOutput("no_rerun_busy", 64'(busy), 64'(0));
         checkOutput("no_rerun_valid", 64'(outValid), 64'(0));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      start     = 1'b0;
      firstAddr = '0;
      lastAddr  = '0;
      outReady  = 1'b1;
      for (int i = 0; i < 32; i++) regs[i] = 32'(100 + i);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_rd_addr", 64'(rdAddr), 64'(0));
      checkOutput("rst_out_addr", 64'(outAddr), 64'(0));
      checkOutput("rst_out_data", 64'(outData), 64'(0));
      checkOutput("rst_valid", 64'(outValid), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      reset = 1'b0;
      @(posedge clk); #1;

      applyStimulus(5'd0, 5'd3, 0, 1'b0);
      applyStimulus(5'd30, 5'd1, 0, 1'b0);
      applyStimulus(5'd7, 5'd7, 0, 1'b0);
      applyStimulus(5'd2, 5'd3, 3, 1'b0);
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      applyStimulus(5'd5, 5'd4, 0, 1'b0);
      applyStimulus(5'd10, 5'd14, 1, 1'b1);

      // Abort a full sweep while a word is on offer.
      firstAddr = 5'd0;
      lastAddr  = 5'd31;
      start     = 1'b1;
      outReady  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("abort_in_send", 64'(outValid), 64'(1));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("abort_rd_addr", 64'(rdAddr), 64'(0));
      checkOutput("abort_out_addr", 64'(outAddr), 64'(0));
      checkOutput("abort_out_data", 64'(outData), 64'(0));
      checkOutput("abort_valid", 64'(outValid), 64'(0));
      checkOutput("abort_busy", 64'(busy), 64'(0));
      checkOutput("abort_done", 64'(done), 64'(0));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checkOutput("abort_quiet_done", 64'(done), 64'(0));
         checkOutput("abort_quiet_valid", 64'(outValid), 64'(0));
      end
      applyStimulus(5'd9, 5'd12, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
